// File: rtl/branch_predict_ctrl.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating counters, table init sequencer,
// resolve-driven updates, mispredict redirect and saturating statistics.
`timescale 1ns/1ps
module branch_predict_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [WORD_SIZE-1:0] fetch_pc,
  output logic [WORD_SIZE-1:0] prediction,
  output logic                 pred_taken,
  output logic                 init_busy,
  input  logic                 res_valid,
  input  logic [WORD_SIZE-1:0] res_pc,
  input  logic                 res_taken,
  input  logic [WORD_SIZE-1:0] res_target,
  input  logic [WORD_SIZE-1:0] res_pred_next,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] stat_branches,
  output logic [WORD_SIZE-1:0] stat_mispred
);

  // state   | meaning
  // S_INIT  | walking r_init_idx over the table, invalidating entries; IF stalls
  // S_RUN   | lookups and resolve updates active
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam int N        = 2**IDX_BITS;
  localparam int TAG_BITS = WORD_SIZE - IDX_BITS;

  state_t r_state, w_next_state;

  logic [IDX_BITS-1:0]  r_init_idx;
  logic [N-1:0]         r_valid;
  logic [1:0]           r_ctr    [N];
  logic [TAG_BITS-1:0]  r_tag    [N];
  logic [WORD_SIZE-1:0] r_target [N];

  logic                 w_run;
  logic [IDX_BITS-1:0]  w_f_idx, w_r_idx;
  logic [TAG_BITS-1:0]  w_f_tag, w_r_tag;
  logic                 w_f_hit, w_r_hit;
  logic [WORD_SIZE-1:0] w_fetch_inc, w_res_inc, w_actual_next;
  logic                 w_accept, w_update, w_write_target;

  assign w_run          = (r_state == S_RUN);
  assign w_f_idx        = fetch_pc[IDX_BITS-1:0];
  assign w_f_tag        = fetch_pc[WORD_SIZE-1:IDX_BITS];
  assign w_r_idx        = res_pc[IDX_BITS-1:0];
  assign w_r_tag        = res_pc[WORD_SIZE-1:IDX_BITS];
  assign w_f_hit        = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_r_hit        = r_valid[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
  assign w_fetch_inc    = fetch_pc + WORD_SIZE'(1);
  assign w_res_inc      = res_pc + WORD_SIZE'(1);
  assign w_actual_next  = res_taken ? res_target : w_res_inc;
  assign w_accept       = w_run && res_valid;
  // clear in the same cycle as a resolve drops the table write but keeps redirect/stats
  assign w_update       = w_accept && !clear;
  assign w_write_target = w_update && res_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:  if (r_init_idx == IDX_BITS'(N-1)) w_next_state = S_RUN;
      S_RUN:   if (clear) w_next_state = S_INIT;
      default: w_next_state = S_INIT;
    endcase
  end

  always_comb begin
    init_busy      = 1'b1;
    pred_taken     = 1'b0;
    prediction     = w_fetch_inc;
    redirect_valid = 1'b0;
    redirect_pc    = w_res_inc;
    if (w_run) begin
      init_busy = 1'b0;
      if (w_f_hit && r_ctr[w_f_idx][1]) begin
        prediction = r_target[w_f_idx];
        pred_taken = 1'b1;
      end
      if (res_valid) begin
        redirect_valid = (w_actual_next != res_pred_next);
        redirect_pc    = w_actual_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_init_idx <= '0;
      r_valid    <= '0;
      for (int i = 0; i < N; i++) r_ctr[i] <= 2'b01;
    end else if (!w_run) begin
      r_valid[r_init_idx] <= 1'b0;
      r_ctr[r_init_idx]   <= 2'b01;
      r_init_idx          <= r_init_idx + IDX_BITS'(1);
    end else if (clear) begin
      r_init_idx <= '0;
    end else if (res_valid) begin
      if (w_r_hit) begin
        if (res_taken) begin
          if (r_ctr[w_r_idx] != 2'b11) r_ctr[w_r_idx] <= r_ctr[w_r_idx] + 2'd1;
        end else begin
          if (r_ctr[w_r_idx] != 2'b00) r_ctr[w_r_idx] <= r_ctr[w_r_idx] - 2'd1;
        end
      end else if (res_taken) begin
        r_valid[w_r_idx] <= 1'b1;
        r_ctr[w_r_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target are plain storage; validity is governed by r_valid alone.
  always_ff @(posedge clk) begin
    if (w_write_target) begin
      r_tag[w_r_idx]    <= w_r_tag;
      r_target[w_r_idx] <= res_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (w_accept) begin
      if (stat_branches != '1) stat_branches <= stat_branches + WORD_SIZE'(1);
      if (redirect_valid && (stat_mispred != '1)) stat_mispred <= stat_mispred + WORD_SIZE'(1);
    end
  end

endmodule
